mseq_burst_ctrl: RTL and testbench

Controller that sequences a 4-bit maximal-length PN (M-sequence) generator in bursts for the modulation test chain. It takes a start command with a burst length, (re)seeds the LFSR and streams chips to the downstream modulator through a valid/ready handshake. It flags the start of each 15-chip period and the last chip of the burst, and reports completion.

---
 rtl/mseq_pkg.sv | 21 ++
 rtl/mseq_lfsr.sv | 29 ++
 rtl/mseq_burst_ctrl.sv | 104 ++++++++++
 tb/tb_mseq_burst_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// Shared types and constants for the burst-sequenced 4-bit M-sequence generator.
package mseq_pkg;

  localparam int                MSEQ_W        = 4;
  localparam logic [MSEQ_W-1:0] MSEQ_DEF_SEED = 4'b0110;
  localparam int                MSEQ_PERIOD   = 15;
  localparam int                MSEQ_TAP_LO   = 0;
  localparam int                MSEQ_TAP_HI   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Right shift with the x^4 + x^3 + 1 feedback entering at the top bit.
  function automatic logic [MSEQ_W-1:0] lfsr_next(input logic [MSEQ_W-1:0] s);
    return {s[MSEQ_TAP_LO] ^ s[MSEQ_TAP_HI], s[MSEQ_W-1:1]};
  endfunction

endpackage

// File: rtl/mseq_lfsr.sv
// 4-bit PN register: synchronous load has priority over stepping.
module mseq_lfsr
  import mseq_pkg::*;
#(
  parameter logic [MSEQ_W-1:0] RST_SEED = MSEQ_DEF_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [MSEQ_W-1:0] seed_i,
  output logic [MSEQ_W-1:0] state_o
);

  logic [MSEQ_W-1:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= RST_SEED;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (en_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mseq_burst_ctrl.sv
// Burst controller: seeds the PN register, streams chips over valid/ready, flags period/burst edges.
module mseq_burst_ctrl
  import mseq_pkg::*;
#(
  parameter int                LFSR_W   = MSEQ_W,
  parameter logic [LFSR_W-1:0] DEF_SEED = MSEQ_DEF_SEED,
  parameter int                LEN_W    = 16,
  parameter int                PERIOD   = MSEQ_PERIOD
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              abort,
  output logic              chip_out,
  output logic              chip_valid,
  input  logic              chip_ready,
  output logic              chip_sof,
  output logic              chip_last,
  output logic              busy,
  output logic              done,
  output logic              seed_err,
  output logic [LFSR_W-1:0] lfsr_state
);

  state_e            state_q;
  logic [LFSR_W-1:0] seed_reg_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [3:0]        phase_q;
  logic              done_q;
  logic              seed_err_q;
  logic [LFSR_W-1:0] lfsr_w;
  logic              xfer;

  assign xfer = (state_q == RUN) && chip_ready;

  mseq_lfsr #(
    .RST_SEED (DEF_SEED)
  ) u_lfsr (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst_n),
    .load_i  (state_q == LOAD),
    .en_i    (xfer),
    .seed_i  (seed_reg_q),
    .state_o (lfsr_w)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q    <= IDLE;
      seed_reg_q <= DEF_SEED;
      cnt_q      <= '0;
      phase_q    <= '0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // An all-zero seed would lock the register, so it is replaced and flagged.
          if (seed_we) begin
            seed_reg_q <= (seed_in == '0) ? DEF_SEED : seed_in;
            seed_err_q <= (seed_in == '0);
          end
          if (start) begin
            if (burst_len == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= burst_len;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          phase_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (xfer) begin
            cnt_q   <= cnt_q - 1'b1;
            phase_q <= (phase_q == 4'(PERIOD - 1)) ? 4'd0 : phase_q + 4'd1;
          end
          if ((xfer && cnt_q == LEN_W'(1)) || abort) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chip_out   = lfsr_w[0];
  assign chip_valid = (state_q == RUN);
  assign chip_sof   = chip_valid && (phase_q == 4'd0);
  assign chip_last  = chip_valid && (cnt_q == LEN_W'(1));
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign seed_err   = seed_err_q;
  assign lfsr_state = lfsr_w;

endmodule

// File: tb/tb_mseq_burst_ctrl.sv
// Bench for mseq_burst_ctrl: per-scenario tasks checked against a recurrence-based chip model.
module tb_mseq_burst_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] burst_len;
  logic        seed_we;
  logic [3:0]  seed_in;
  logic        abort;
  logic        chip_ready;
  logic        chip_out, chip_valid, chip_sof, chip_last, busy, done, seed_err;
  logic [3:0]  lfsr_state;

  mseq_burst_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .burst_len  (burst_len),
    .seed_we    (seed_we),
    .seed_in    (seed_in),
    .abort      (abort),
    .chip_out   (chip_out),
    .chip_valid (chip_valid),
    .chip_ready (chip_ready),
    .chip_sof   (chip_sof),
    .chip_last  (chip_last),
    .busy       (busy),
    .done       (done),
    .seed_err   (seed_err),
    .lfsr_state (lfsr_state)
  );

  always #5 sys_clk = ~sys_clk;

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  cur_seed;
  logic        exp_err;
  logic        exp_o [0:299];
  logic [63:0] obs_v;

  // Output chip n+4 = chip n XOR chip n+3; the first four chips are the seed bits.
  function automatic void build_seq(input logic [3:0] s);
    for (int i = 0; i < 4; i++) exp_o[i] = s[i];
    for (int n = 0; n < 296; n++) exp_o[n+4] = exp_o[n] ^ exp_o[n+3];
  endfunction

  function automatic logic [3:0] exp_state(input int k);
    return {exp_o[k+3], exp_o[k+2], exp_o[k+1], exp_o[k]};
  endfunction

  task automatic write_seed(input logic [3:0] v);
    @(negedge sys_clk);
    seed_we = 1'b1;
    seed_in = v;
    @(negedge sys_clk);
    seed_we = 1'b0;
    cur_seed = (v == 4'd0) ? 4'b0110 : v;
    exp_err  = (v == 4'd0);
    tests++;
    if (seed_err !== exp_err) begin
      fails++;
      $display("FAIL seed_err_after_write got=%b exp=%b (seed %h)", seed_err, exp_err, v);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: three-cycle stall after chip 1
  task automatic run_burst(input int len, input int mode, input int abort_at,
                           input bit inject, input string tag);
    int  k, cyc, stall;
    bit  ended, r, ab;
    build_seq(cur_seed);
    obs_v = '0;
    @(negedge sys_clk);
    start = 1'b1;
    burst_len = 16'(len);
    @(negedge sys_clk);
    start = 1'b0;
    burst_len = 16'($urandom);
    tests++;
    if (chip_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_load valid=%b busy=%b exp valid=0 busy=1", tag, chip_valid, busy);
    end
    @(negedge sys_clk);
    k = 0; cyc = 0; stall = 0; ended = 0;
    while (!ended) begin
      if (cyc > len * 6 + 40) begin
        tests++; fails++;
        $display("FAIL %s_timeout chips=%0d exp=%0d", tag, k, len);
        break;
      end
      tests++;
      if (chip_valid !== 1'b1 || chip_out !== exp_o[k] || chip_sof !== (k % 15 == 0) ||
          chip_last !== (k == len - 1) || lfsr_state !== exp_state(k) ||
          busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s_chip%0d got v=%b c=%b sof=%b last=%b st=%h busy=%b done=%b exp v=1 c=%b sof=%b last=%b st=%h busy=1 done=0",
                 tag, k, chip_valid, chip_out, chip_sof, chip_last, lfsr_state, busy, done,
                 exp_o[k], (k % 15 == 0), (k == len - 1), exp_state(k));
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !(k == 2 && stall < 3);
      endcase
      if (!r) stall++;
      ab = (abort_at >= 0 && k == abort_at);
      chip_ready = r;
      abort = ab;
      if (inject && k == 3) begin
        start = 1'b1;
        burst_len = 16'd7;
        seed_we = 1'b1;
        seed_in = 4'b1111;
      end
      if (r && k < 64) obs_v[k] = chip_out;
      @(negedge sys_clk);
      cyc++;
      abort = 1'b0;
      start = 1'b0;
      seed_we = 1'b0;
      if (r) k++;
      if ((r && k == len) || ab) ended = 1;
    end
    chip_ready = 1'b1;
    tests++;
    if (done !== 1'b1 || chip_valid !== 1'b0 || busy !== 1'b0 || chip_sof !== 1'b0 ||
        chip_last !== 1'b0 || lfsr_state !== exp_state(k)) begin
      fails++;
      $display("FAIL %s_end done=%b v=%b busy=%b sof=%b last=%b st=%h exp done=1 v=0 busy=0 sof=0 last=0 st=%h",
               tag, done, chip_valid, busy, chip_sof, chip_last, lfsr_state, exp_state(k));
    end
    @(negedge sys_clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_width done=%b busy=%b exp 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1; start = 1'b0; burst_len = '0; seed_we = 1'b0; seed_in = '0;
    abort = 1'b0; chip_ready = 1'b1;
    cur_seed = 4'b0110; exp_err = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    tests++;
    if ({chip_out, chip_valid, chip_sof, chip_last, busy, done, seed_err} !== 7'b0 ||
        lfsr_state !== 4'b0110) begin
      fails++;
      $display("FAIL reset_state outs=%b st=%h exp outs=0000000 st=6",
               {chip_out, chip_valid, chip_sof, chip_last, busy, done, seed_err}, lfsr_state);
    end
  endtask

  task automatic test_basic();
    logic [14:0] exp_basic;
    exp_basic = 15'b101111000100110;
    run_burst(15, 0, -1, 1'b0, "basic");
    tests++;
    if (obs_v[14:0] !== exp_basic) begin
      fails++;
      $display("FAIL basic_stream got=%b exp=%b", obs_v[14:0], exp_basic);
    end
  endtask

  task automatic test_wrap();
    run_burst(32, 0, -1, 1'b0, "wrap");
    tests++;
    if (obs_v[29:15] !== obs_v[14:0]) begin
      fails++;
      $display("FAIL wrap_repeat got=%b exp=%b", obs_v[29:15], obs_v[14:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_bp;
    exp_bp = 5'b00110;
    run_burst(5, 2, -1, 1'b0, "bp");
    tests++;
    if (obs_v[4:0] !== exp_bp) begin
      fails++;
      $display("FAIL bp_stream got=%b exp=%b", obs_v[4:0], exp_bp);
    end
  endtask

  task automatic test_seed();
    logic [3:0] exp_a, exp_b;
    exp_a = 4'b0001;
    exp_b = 4'b0110;
    write_seed(4'b0001);
    run_burst(4, 0, -1, 1'b0, "seed1");
    tests++;
    if (obs_v[3:0] !== exp_a) begin
      fails++;
      $display("FAIL seed1_stream got=%b exp=%b", obs_v[3:0], exp_a);
    end
    write_seed(4'b0000);
    run_burst(4, 0, -1, 1'b0, "seed0");
    tests++;
    if (obs_v[3:0] !== exp_b) begin
      fails++;
      $display("FAIL seed0_stream got=%b exp=%b", obs_v[3:0], exp_b);
    end
  endtask

  task automatic test_abort();
    run_burst(100, 0, 7, 1'b0, "abort");
    run_burst(3, 0, -1, 1'b0, "after_abort");
  endtask

  task automatic test_corner();
    @(negedge sys_clk);
    start = 1'b1;
    burst_len = 16'd0;
    @(negedge sys_clk);
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || chip_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_len done=%b v=%b busy=%b exp 1 0 0", done, chip_valid, busy);
    end
    @(negedge sys_clk);
    tests++;
    if (done !== 1'b0 || chip_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_after done=%b v=%b exp 0 0", done, chip_valid);
    end
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle done=%b busy=%b exp 0 0", done, busy);
    end
    run_burst(12, 0, -1, 1'b1, "start_in_run");
    run_burst(6, 0, -1, 1'b0, "seed_kept");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) != 0) write_seed(($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom));
      run_burst(int'($urandom_range(1, 40)), 1,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1, 1'b0, "rand");
    end
  endtask

  task automatic test_reset_mid();
    write_seed(4'b0000);
    @(negedge sys_clk);
    start = 1'b1;
    burst_len = 16'd100;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (6) @(negedge sys_clk);
    tests++;
    if (chip_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_running v=%b exp 1", chip_valid);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    tests++;
    if ({chip_out, chip_valid, chip_sof, chip_last, busy, done, seed_err} !== 7'b0 ||
        lfsr_state !== 4'b0110) begin
      fails++;
      $display("FAIL rst_mid_state outs=%b st=%h exp outs=0000000 st=6",
               {chip_out, chip_valid, chip_sof, chip_last, busy, done, seed_err}, lfsr_state);
    end
    cur_seed = 4'b0110;
    exp_err = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_no_done done=%b busy=%b exp 0 0", done, busy);
      end
    end
    run_burst(5, 0, -1, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_seed();
    test_abort();
    test_corner();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
